// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared write-response codes, FSM encodings and merge helper
package br_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } br_state_t;

  // Severity order matches the numeric code order, so the merge is a plain max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/br_channel_controller_if.sv
// rtl/br_channel_controller_if.sv - write-response routing bus; BR_ERR_STICKY_EN adds sticky error ports
interface br_channel_controller_if #(
  parameter int Slaves_ID_Size = 1
);
  logic [Slaves_ID_Size-1:0] Write_Data_Master;
  logic                      Write_Data_Finsh;
  logic                      Is_Master_Part_Of_Split;
  logic [1:0]                M00_AXI_bresp;
  logic                      M00_AXI_bvalid;
  logic                      M00_AXI_bready;
  logic [1:0]                S00_AXI_bresp;
  logic                      S00_AXI_bvalid;
  logic                      S00_AXI_bready;
  logic [1:0]                S01_AXI_bresp;
  logic                      S01_AXI_bvalid;
  logic                      S01_AXI_bready;
  logic                      Resp_Queue_Full;
  logic                      Resp_Queue_Empty;
`ifdef BR_ERR_STICKY_EN
  logic                      Resp_Error_Clear;
  logic [1:0]                Resp_Error_Sticky;
`endif

  modport slave (
    input  Write_Data_Master, Write_Data_Finsh, Is_Master_Part_Of_Split,
    input  M00_AXI_bresp, M00_AXI_bvalid, S00_AXI_bready, S01_AXI_bready,
`ifdef BR_ERR_STICKY_EN
    input  Resp_Error_Clear,
    output Resp_Error_Sticky,
`endif
    output M00_AXI_bready, S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid,
    output Resp_Queue_Full, Resp_Queue_Empty
  );

  modport master (
    output Write_Data_Master, Write_Data_Finsh, Is_Master_Part_Of_Split,
    output M00_AXI_bresp, M00_AXI_bvalid, S00_AXI_bready, S01_AXI_bready,
`ifdef BR_ERR_STICKY_EN
    output Resp_Error_Clear,
    input  Resp_Error_Sticky,
`endif
    input  M00_AXI_bready, S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid,
    input  Resp_Queue_Full, Resp_Queue_Empty
  );

endinterface

// File: rtl/br_resp_fifo.sv
// rtl/br_resp_fifo.sv - in-order queue of outstanding write responses
module br_resp_fifo #(
  parameter int Depth = 4,
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int Aw = $clog2(Depth);

  logic [Aw:0]      wr_ptr_q;
  logic [Aw:0]      rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en;
  logic             pop_en;

  assign full    = (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]) && (wr_ptr_q[Aw] != rd_ptr_q[Aw]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign pop_en  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign dout    = mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[Aw-1:0]] <= din;
  end

endmodule

// File: rtl/br_channel_controller.sv
// rtl/br_channel_controller.sv - routes/merges M00 write responses to S00/S01
// Optional BR_ERR_STICKY_EN: sticky record of forwarded error responses.
module br_channel_controller
  import br_pkg::*;
#(
  parameter int Slaves_Num       = 2,
  parameter int Slaves_ID_Size   = $clog2(Slaves_Num),
  parameter int Resp_Queue_Depth = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  br_channel_controller_if.slave  bus
);

  localparam int Entry_W = Slaves_ID_Size + 1;

  br_state_t                 state_q;
  logic [1:0]                acc_q;
  logic [1:0]                out_resp_q;
  logic [Slaves_ID_Size-1:0] out_id_q;
  logic [Entry_W-1:0]        head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      head_split;
  logic [Slaves_ID_Size-1:0] head_id;
  logic                      m_hs;
  logic                      id_in_range;
  logic                      s_ready;
  logic                      s_hs;

  br_resp_fifo #(
    .Depth (Resp_Queue_Depth),
    .Width (Entry_W)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (bus.Write_Data_Finsh),
    .din   ({bus.Write_Data_Master, bus.Is_Master_Part_Of_Split}),
    .pop   (m_hs),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_split  = head[0];
  assign head_id     = head[Entry_W-1:1];
  assign m_hs        = (state_q == ST_IDLE) && !fifo_empty && bus.M00_AXI_bvalid;
  assign id_in_range = int'(out_id_q) < Slaves_Num;
  assign s_ready     = (int'(out_id_q) == 0) ? bus.S00_AXI_bready :
                       (int'(out_id_q) == 1) ? bus.S01_AXI_bready : 1'b0;
  assign s_hs        = (state_q == ST_RESP) && id_in_range && s_ready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      acc_q      <= RESP_OKAY;
      out_resp_q <= RESP_OKAY;
      out_id_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m_hs) begin
            // Intermediate split parts only fold into the accumulator.
            if (head_split) begin
              acc_q <= resp_max(acc_q, bus.M00_AXI_bresp);
            end else begin
              out_resp_q <= resp_max(acc_q, bus.M00_AXI_bresp);
              out_id_q   <= head_id;
              acc_q      <= RESP_OKAY;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (!id_in_range || s_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.M00_AXI_bready   = (state_q == ST_IDLE) && !fifo_empty;
  assign bus.S00_AXI_bvalid   = (state_q == ST_RESP) && (int'(out_id_q) == 0);
  assign bus.S01_AXI_bvalid   = (state_q == ST_RESP) && (int'(out_id_q) == 1);
  assign bus.S00_AXI_bresp    = bus.S00_AXI_bvalid ? out_resp_q : RESP_OKAY;
  assign bus.S01_AXI_bresp    = bus.S01_AXI_bvalid ? out_resp_q : RESP_OKAY;
  assign bus.Resp_Queue_Full  = fifo_full;
  assign bus.Resp_Queue_Empty = fifo_empty;

`ifdef BR_ERR_STICKY_EN
  logic [1:0] sticky_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sticky_q <= RESP_OKAY;
    end else if (bus.Resp_Error_Clear) begin
      sticky_q <= RESP_OKAY;
    end else if (s_hs && out_resp_q[1]) begin
      sticky_q <= resp_max(sticky_q, out_resp_q);
    end
  end

  assign bus.Resp_Error_Sticky = sticky_q;
`else
  logic unused_s_hs;
  assign unused_s_hs = s_hs;
`endif

endmodule

// File: doc/br_channel_controller.md
Name: br_channel_controller

Overview:
- Write-response (B) stage downstream of the write-data channel controller for one slave-side port (M00).
- Records, in order, which master finished each write-data burst; routes the M00 B response back to S00 or S01.
- For split transactions, absorbs the intermediate response and returns one merged response to the originating master.
- Back-pressures the address/data path through a full flag.

Parameters:
- Slaves_Num, 2, number of upstream masters (S ports).
- Slaves_ID_Size, $clog2(Slaves_Num), width of the master ID.
- Resp_Queue_Depth, 4, outstanding-response entries; power of two, at least 2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- Write_Data_Master  in  Slaves_ID_Size  master whose data burst just completed.
- Write_Data_Finsh  in  1  one-cycle pulse: data burst complete; push entry.
- Is_Master_Part_Of_Split  in  1  sampled with Finsh; 1 means more split parts follow.
- M00_AXI_bresp  in  2  slave response.
- M00_AXI_bvalid  in  1  slave response valid.
- M00_AXI_bready  out  1  response accept toward slave.
- S00_AXI_bresp  out  2  response to master 0.
- S00_AXI_bvalid  out  1  response valid to master 0.
- S00_AXI_bready  in  1  master 0 accept.
- S01_AXI_bresp  out  2  response to master 1.
- S01_AXI_bvalid  out  1  response valid to master 1.
- S01_AXI_bready  in  1  master 1 accept.
- Resp_Queue_Full  out  1  queue holds Resp_Queue_Depth entries.
- Resp_Queue_Empty  out  1  no outstanding entry.

Behaviour:
- Queue: FIFO of {master_id, split}.
  - Push on Write_Data_Finsh when not full, or when full with a pop in the same cycle.
  - A push while full with no pop is ignored. Upstream must stall on Resp_Queue_Full.
  - Pointers carry one extra wrap bit. Full = indices equal and wrap bits differ. Empty = pointers equal.
- FSM states: IDLE, RESP.
  - IDLE: M00_AXI_bready = ~Resp_Queue_Empty. A handshake (bvalid & bready) pops the head.
    - Head split=1: acc <= max(acc, bresp); stay in IDLE; nothing is forwarded.
    - Head split=0: out_resp <= max(acc, bresp); out_id <= head id; acc <= OKAY; go to RESP.
  - RESP: M00_AXI_bready = 0. S[out_id]_AXI_bvalid = 1 and S[out_id]_AXI_bresp = out_resp; the other S port drives bvalid 0 and bresp 00.
    - On S[out_id]_AXI_bready = 1, go to IDLE in the next cycle.
- Latency:
  - Sxx bvalid rises 1 cycle after the M00 handshake.
  - Earliest next M00 bready is 1 cycle after the Sxx handshake.
- Merge rule: numeric max of bresp codes (OKAY 00 < EXOKAY 01 < SLVERR 10 < DECERR 11).
- A push and a pop in the same cycle are both performed; the count is unchanged.
- A push into an empty queue is visible at the head the next cycle. No same-cycle bypass.
- M00 bvalid while the queue is empty: bready stays 0 and the response waits.
- Out-of-range out_id (greater than or equal to Slaves_Num): drive no S bvalid and return to IDLE.
- Reset (asynchronous, any state):
  - Pointers 0, acc 00, out_resp 00, out_id 0, state IDLE.
  - All bvalid/bready outputs 0, Resp_Queue_Empty 1, Resp_Queue_Full 0.
  - In-flight entries are discarded.

Optional Feature:
- Macro BR_ERR_STICKY_EN.
- Defined:
  - Adds input Resp_Error_Clear (1 bit) and output Resp_Error_Sticky (2 bits, reset 00).
  - On each forwarded response, Resp_Error_Sticky <= max(Resp_Error_Sticky, out_resp) if out_resp[1] = 1.
  - Resp_Error_Clear zeroes it. Clear wins over a same-cycle update.
- Undefined: these ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Shared package br_pkg holds:
  - BRESP code localparams (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR).
  - FSM state encodings (ST_IDLE, ST_RESP).
  - A resp_max function.
- One sub-module: br_resp_fifo.
  - Parameterised depth and width; push/pop/full/empty; head-data output.
  - The top holds the FSM, merge logic and routing.

Test Plan:
- Single write: Finsh with id=1, split=0; M00 bvalid with bresp=00 -> bready=1 that cycle; next cycle S01 bvalid=1 with bresp=00; S00 bvalid stays 0.
- Split merge: push (id=0, split=1) then (id=0, split=0); M00 responses 10 then 00 -> exactly one S00 response, bresp=10; M00 sees two handshakes.
- Ordering: push ids 0, 1, 0, 1 (split=0); M00 returns 00, 11, 01, 00 -> S00 gets 00; S01 gets 11; S00 gets 01; S01 gets 00, in that order.
- Full and simultaneous events:
  - 4 pushes -> Full=1; a 5th push is ignored; count stays 4.
  - Push and pop in the same cycle while full -> count stays 4; the new entry appears last.
- Backpressure and reset:
  - Hold S00 bready=0 for 5 cycles in RESP -> bvalid held; M00 bready=0 throughout.
  - Assert ARESETN=0 mid-RESP -> all outputs 0 immediately; Empty=1.
- BR_ERR_STICKY_EN: forward responses 10, then 00 -> Sticky=10; then 11 -> Sticky=11; Clear pulse together with a 10 response -> Sticky=00.
